// File: rtl/muldiv_control_sequencer_pkg.sv
// Shared definitions for the multiply/divide control sequencer:
// state encoding, opcode constants, IR field positions and the control word.
package muldiv_control_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7
    } state_t;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    // IR field bit positions
    localparam int IR_OPC_MSB = 31;
    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_MSB  = 26;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_MSB  = 22;
    localparam int IR_RB_LSB  = 19;

    // One control word per cycle; field order is the datapath strobe set.
    typedef struct packed {
        logic       pc_sel;
        logic       zlo_sel;
        logic       zhi_sel;
        logic       mdr_sel;
        logic       ra_sel;
        logic       rb_sel;
        logic       pc_en;
        logic       pc_inc_en;
        logic       ir_en;
        logic       y_en;
        logic       z_en;
        logic       mar_en;
        logic       mdr_en;
        logic       lo_en;
        logic       hi_en;
        logic       rd;
        logic [4:0] alu;
        logic       busy;
        logic       illegal_op;
    } ctrl_t;

    // Only multiply and divide are executed by this sequencer.
    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_decode.sv
// Combinational decoder: state (the one about to be entered) plus opcode
// to the control word for that state.
module muldiv_ctrl_decode
    import muldiv_control_sequencer_pkg::*;
(
    input  state_t     state_i,
    input  logic [4:0] opcode_i,
    output ctrl_t      ctrl_o
);

    // Map each state to its strobes; anything not listed stays low.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_T0: begin
                ctrl_o.pc_sel    = 1'b1;
                ctrl_o.mar_en    = 1'b1;
                ctrl_o.pc_inc_en = 1'b1;
                ctrl_o.z_en      = 1'b1;
                ctrl_o.busy      = 1'b1;
            end
            S_T1: begin
                ctrl_o.zlo_sel = 1'b1;
                ctrl_o.pc_en   = 1'b1;
                ctrl_o.rd      = 1'b1;
                ctrl_o.mdr_en  = 1'b1;
                ctrl_o.busy    = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_sel = 1'b1;
                ctrl_o.ir_en   = 1'b1;
                ctrl_o.busy    = 1'b1;
            end
            S_T3: begin
                ctrl_o.ra_sel = 1'b1;
                ctrl_o.y_en   = 1'b1;
                ctrl_o.busy   = 1'b1;
            end
            S_T4: begin
                ctrl_o.rb_sel = 1'b1;
                ctrl_o.busy   = 1'b1;
                if (is_legal_op(opcode_i)) begin
                    ctrl_o.z_en = 1'b1;
                    ctrl_o.alu  = opcode_i;
                end else begin
                    ctrl_o.illegal_op = 1'b1;
                end
            end
            S_T5: begin
                ctrl_o.zlo_sel = 1'b1;
                ctrl_o.lo_en   = 1'b1;
                ctrl_o.busy    = 1'b1;
            end
            S_T6: begin
                ctrl_o.zhi_sel = 1'b1;
                ctrl_o.hi_en   = 1'b1;
                ctrl_o.busy    = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_control_sequencer.sv
// Multiply/divide instruction sequencer: IDLE, T0..T6. Outputs are registered
// from the decode of the next state, so they line up exactly with the state
// register and clear immediately on reset.
module muldiv_control_sequencer
    import muldiv_control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR_Data,
    output logic        PC_select,
    output logic        Z_LO_select,
    output logic        Z_HI_select,
    output logic        MDR_select,
    output logic        Ra_select,
    output logic        Rb_select,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        LO_enable,
    output logic        HI_enable,
    output logic        read,
    output logic [4:0]  alu_instruction,
    output logic        busy,
    output logic        done,
    output logic        illegal_op
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       done_q, done_d;
    logic [4:0] opcode_s;
    logic       ir_unused_s;

    // IR is read live (stable from T3 on); register fields are resolved downstream.
    assign opcode_s    = IR_Data[IR_OPC_MSB:IR_OPC_LSB];
    assign ir_unused_s = ^IR_Data[IR_RA_MSB:0];

    // Next-state logic; the opcode check at T4 decides between T5 and abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: state_d = S_T4;
            S_T4: begin
                if (is_legal_op(opcode_s)) begin
                    state_d = S_T5;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T5: state_d = S_T6;
            S_T6: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_q == S_T6);
    end

    muldiv_ctrl_decode u_decode (
        .state_i  (state_d),
        .opcode_i (opcode_s),
        .ctrl_o   (ctrl_d)
    );

    // State and registered control word; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    assign PC_select           = ctrl_q.pc_sel;
    assign Z_LO_select         = ctrl_q.zlo_sel;
    assign Z_HI_select         = ctrl_q.zhi_sel;
    assign MDR_select          = ctrl_q.mdr_sel;
    assign Ra_select           = ctrl_q.ra_sel;
    assign Rb_select           = ctrl_q.rb_sel;
    assign PC_enable           = ctrl_q.pc_en;
    assign PC_increment_enable = ctrl_q.pc_inc_en;
    assign IR_enable           = ctrl_q.ir_en;
    assign Y_enable            = ctrl_q.y_en;
    assign Z_enable            = ctrl_q.z_en;
    assign MAR_enable          = ctrl_q.mar_en;
    assign MDR_enable          = ctrl_q.mdr_en;
    assign LO_enable           = ctrl_q.lo_en;
    assign HI_enable           = ctrl_q.hi_en;
    assign read                = ctrl_q.rd;
    assign alu_instruction     = ctrl_q.alu;
    assign busy                = ctrl_q.busy;
    assign done                = done_q;
    assign illegal_op          = ctrl_q.illegal_op;

endmodule

// File: tb/tb_muldiv_control_sequencer.sv
// Scoreboard bench for muldiv_control_sequencer: each scenario queues the
// expected per-cycle output vector, then drains the queue one cycle at a time.
module tb_muldiv_control_sequencer;

    typedef struct packed {
        logic       pc_sel;
        logic       zlo_sel;
        logic       zhi_sel;
        logic       mdr_sel;
        logic       ra_sel;
        logic       rb_sel;
        logic       pc_en;
        logic       pc_inc;
        logic       ir_en;
        logic       y_en;
        logic       z_en;
        logic       mar_en;
        logic       mdr_en;
        logic       lo_en;
        logic       hi_en;
        logic       rd;
        logic [4:0] alu;
        logic       busy;
        logic       done;
        logic       ill;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] IR_Data;
    logic PC_select, Z_LO_select, Z_HI_select, MDR_select, Ra_select, Rb_select;
    logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic MAR_enable, MDR_enable, LO_enable, HI_enable, read;
    logic [4:0] alu_instruction;
    logic busy, done, illegal_op;

    obs_t obs;
    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    muldiv_control_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .run                 (run),
        .IR_Data             (IR_Data),
        .PC_select           (PC_select),
        .Z_LO_select         (Z_LO_select),
        .Z_HI_select         (Z_HI_select),
        .MDR_select          (MDR_select),
        .Ra_select           (Ra_select),
        .Rb_select           (Rb_select),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .LO_enable           (LO_enable),
        .HI_enable           (HI_enable),
        .read                (read),
        .alu_instruction     (alu_instruction),
        .busy                (busy),
        .done                (done),
        .illegal_op          (illegal_op)
    );

    assign obs = {PC_select, Z_LO_select, Z_HI_select, MDR_select, Ra_select, Rb_select,
                  PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                  MAR_enable, MDR_enable, LO_enable, HI_enable, read,
                  alu_instruction, busy, done, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs: t=0..6 -> T0..T6, 7 -> done cycle, anything else -> quiet IDLE.
    function automatic obs_t exp_vec(input int t, input logic [4:0] op);
        obs_t e;
        e = '0;
        case (t)
            0: begin e.pc_sel = 1'b1; e.mar_en = 1'b1; e.pc_inc = 1'b1; e.z_en = 1'b1; e.busy = 1'b1; end
            1: begin e.zlo_sel = 1'b1; e.pc_en = 1'b1; e.rd = 1'b1; e.mdr_en = 1'b1; e.busy = 1'b1; end
            2: begin e.mdr_sel = 1'b1; e.ir_en = 1'b1; e.busy = 1'b1; end
            3: begin e.ra_sel = 1'b1; e.y_en = 1'b1; e.busy = 1'b1; end
            4: begin
                e.rb_sel = 1'b1;
                e.busy   = 1'b1;
                if (op == 5'b10000 || op == 5'b01111) begin
                    e.z_en = 1'b1;
                    e.alu  = op;
                end else begin
                    e.ill = 1'b1;
                end
            end
            5: begin e.zlo_sel = 1'b1; e.lo_en = 1'b1; e.busy = 1'b1; end
            6: begin e.zhi_sel = 1'b1; e.hi_en = 1'b1; e.busy = 1'b1; end
            7: e.done = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic push_instr(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        for (int t = 0; t < 5; t++) exp_q.push_back(exp_vec(t, op));
        if (op == 5'b10000 || op == 5'b01111) begin
            for (int t = 5; t < 8; t++) exp_q.push_back(exp_vec(t, op));
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(8, 5'b00000));
    endtask

    // Pop and compare one vector per cycle; optionally drop run or pulse it.
    task automatic drain(input string name, input int release_at, input int pulse_at);
        obs_t e;
        int   i;
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, e);
            end else begin
                passes++;
            end
            if (i == release_at) run = 1'b0;
            if (i == pulse_at) run = 1'b1;
            if (i == pulse_at + 1) run = 1'b0;
            i++;
        end
    endtask

    // Every cycle out of reset: at most one bus source drives the bus.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if ($countones({PC_select, Z_LO_select, Z_HI_select, MDR_select}) > 1) begin
                $display("FAIL bus_onehot: got %b expected at most one set",
                         {PC_select, Z_LO_select, Z_HI_select, MDR_select});
            end else begin
                passes++;
            end
        end
    end

    task automatic start_instr(input logic [31:0] ir);
        @(negedge clk);
        IR_Data = ir;
        run     = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== obs_t'('0)) $display("FAIL reset_state: got %h expected %h", obs, obs_t'('0));
        else passes++;
        reset = 1'b0;
        push_idle(3);
        drain("reset_idle", -1, -100);
    endtask

    task automatic test_div();
        start_instr(32'h8338_0000);
        push_instr(32'h8338_0000);
        push_idle(1);
        drain("div", 0, -100);
    endtask

    task automatic test_mul();
        start_instr(32'h7B38_0000);
        push_instr(32'h7B38_0000);
        push_idle(1);
        drain("mul", 0, -100);
    endtask

    task automatic test_illegal();
        start_instr(32'h1800_0000);
        push_instr(32'h1800_0000);
        push_idle(2);
        drain("illegal", 0, -100);
    endtask

    task automatic test_reset_mid_t4();
        start_instr(32'h8338_0000);
        for (int t = 0; t < 5; t++) exp_q.push_back(exp_vec(t, 5'b10000));
        drain("pre_reset", 0, -100);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== obs_t'('0)) $display("FAIL reset_mid_t4: got %h expected %h", obs, obs_t'('0));
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        push_idle(4);
        drain("post_reset", -1, -100);
        start_instr(32'h7B38_0000);
        push_instr(32'h7B38_0000);
        push_idle(1);
        drain("mul_after_reset", 0, -100);
    endtask

    task automatic test_back_to_back();
        start_instr(32'h8338_0000);
        push_instr(32'h8338_0000);
        push_instr(32'h8338_0000);
        push_idle(2);
        drain("back_to_back", 10, -100);
    endtask

    task automatic test_run_ignored();
        start_instr(32'h7B38_0000);
        push_instr(32'h7B38_0000);
        push_idle(3);
        drain("run_ignored", 0, 2);
    endtask

    initial begin
        reset   = 1'b0;
        run     = 1'b0;
        IR_Data = 32'h0000_0000;
        test_reset();
        test_div();
        test_mul();
        test_illegal();
        test_reset_mid_t4();
        test_back_to_back();
        test_run_ignored();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
